// File: rtl/adder_pipe.sv
// Pipelined two's-complement adder/subtractor: one WIDTH/STAGES-bit slice resolved per stage,
// carry registered between stages, valid/ready stream handshake, registered cout/ovf/zero flags.
module adder_pipe #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int unsigned K = WIDTH / STAGES;

   logic             adv;
   logic [WIDTH-1:0] b_eff;

   // Subtraction is A + ~B + 1; the +1 enters as carry-in to slice 0.
   assign b_eff = sub ? ~B : B;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      // Operand bits not yet consumed when entering this stage, and result bits produced so far.
      localparam int unsigned InW  = WIDTH - s * K;
      localparam int unsigned SumW = (s + 1) * K;

      logic [InW-1:0]  a_in;
      logic [InW-1:0]  b_in;
      logic            c_in;
      logic            v_in;
      logic [K:0]      slice;
      logic [SumW-1:0] sum_d;
      logic [SumW-1:0] sum_q;
      logic            c_q;
      logic            v_q;

      if (s == 0) begin : g_first
         assign a_in  = A;
         assign b_in  = b_eff;
         assign c_in  = sub;
         assign v_in  = in_valid;
         assign sum_d = slice[K-1:0];
      end else begin : g_rest
         assign a_in  = g_stage[s-1].g_fwd.a_q;
         assign b_in  = g_stage[s-1].g_fwd.b_q;
         assign c_in  = g_stage[s-1].c_q;
         assign v_in  = g_stage[s-1].v_q;
         assign sum_d = {slice[K-1:0], g_stage[s-1].sum_q};
      end

      assign slice = {1'b0, a_in[K-1:0]} + {1'b0, b_in[K-1:0]} + {{K{1'b0}}, c_in};

      // Bubbles are captured like real beats so every slot moves in lockstep.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            sum_q <= '0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
         end else if (adv) begin
            sum_q <= sum_d;
            c_q   <= slice[K];
            v_q   <= v_in;
         end
      end

      if (s < STAGES - 1) begin : g_fwd
         logic [InW-K-1:0] a_q;
         logic [InW-K-1:0] b_q;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv) begin
               a_q <= a_in[InW-1:K];
               b_q <= b_in[InW-1:K];
            end
         end
      end else begin : g_last
         logic ovf_q;
         logic zero_q;

         // Top slice still carries the operand sign bits, so overflow is resolved here.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (adv) begin
               ovf_q  <= (a_in[K-1] == b_in[K-1]) && (sum_d[SumW-1] != a_in[K-1]);
               zero_q <= (sum_d == '0);
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].v_q;
   assign S         = g_stage[STAGES-1].sum_q;
   assign cout      = g_stage[STAGES-1].c_q;
   assign ovf       = g_stage[STAGES-1].g_last.ovf_q;
   assign zero      = g_stage[STAGES-1].g_last.zero_q;

   assign adv      = out_ready || !out_valid;
   assign in_ready = adv;

endmodule
